// File: rtl/regex_cpu_queued.sv
// Regex execution core with an input pc queue: pops a pc, fetches its instruction, executes it, emits 0..2 pcs.
// Optional perf counters: define REGEX_CPU_PERF_COUNTERS_EN. Instruction word = {opcode[3:0], data}.
module regex_cpu_queued #(
    parameter int PC_WIDTH          = 8,
    parameter int CC_ID_BITS        = 1,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int INPUT_FIFO_DEPTH  = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]   current_characters,
    input  logic                                         input_pc_valid,
    input  logic [PC_WIDTH-1:0]                          input_pc,
    input  logic [CC_ID_BITS-1:0]                        input_cc_id,
    output logic                                         input_pc_ready,
    output logic                                         memory_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                 memory_addr,
    input  logic                                         memory_ready,
    input  logic [MEMORY_WIDTH-1:0]                      memory_data,
    output logic                                         output_pc_valid,
    output logic [PC_WIDTH-1:0]                          output_pc,
    output logic [CC_ID_BITS-1:0]                        output_cc_id,
    input  logic                                         output_pc_ready,
    output logic                                         accepts,
    output logic [CC_ID_BITS-1:0]                        accepts_cc_id,
`ifdef REGEX_CPU_PERF_COUNTERS_EN
    output logic [31:0]                                  perf_instr_count,
    output logic [31:0]                                  perf_accept_count,
`endif
    output logic                                         illegal_opcode
);

    // state    | meaning
    // IDLE     | waiting for a queued pc; pops it when present
    // FETCH    | memory request held until memory_ready
    // WAIT_MEM | instruction word arrives, captured at end of cycle
    // EXEC     | decode and evaluate against current character
    // OUT1     | first (or only) next pc offered
    // OUT2     | second SPLIT target offered

    localparam int OPCODE_WIDTH = 4;
    localparam int DATA_WIDTH   = MEMORY_WIDTH - OPCODE_WIDTH;
    localparam int PTR_W        = $clog2(INPUT_FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int ENTRY_W      = PC_WIDTH + CC_ID_BITS;

    localparam logic [OPCODE_WIDTH-1:0] OP_ACCEPT         = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_SPLIT          = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_MATCH_CHAR     = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP            = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_END_NO_ACCEPT  = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_MATCH_ANY      = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_ACCEPT_PARTIAL = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT_MATCH_CHAR = 4'h7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        EXEC     = 3'd3,
        OUT1     = 3'd4,
        OUT2     = 3'd5
    } state_t;

    logic [ENTRY_W-1:0]           fifo_q [INPUT_FIFO_DEPTH];
    logic [ENTRY_W-1:0]           fifo_d [INPUT_FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         ready_q, ready_d;
    logic                         push, pop;

    state_t                       state_q, state_d;
    logic [PC_WIDTH-1:0]          cur_pc_q, cur_pc_d;
    logic [CC_ID_BITS-1:0]        cur_cc_q, cur_cc_d;
    logic                         mem_valid_q, mem_valid_d;
    logic [MEMORY_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEMORY_WIDTH-1:0]      instr_q, instr_d;
    logic                         out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]          out_pc_q, out_pc_d;
    logic [CC_ID_BITS-1:0]        out_cc_q, out_cc_d;
    logic [PC_WIDTH-1:0]          split_pc_q, split_pc_d;
    logic                         split_pend_q, split_pend_d;
    logic                         accepts_q, accepts_d;
    logic [CC_ID_BITS-1:0]        accepts_cc_q, accepts_cc_d;
    logic                         illegal_q, illegal_d;

    logic [OPCODE_WIDTH-1:0]      opcode;
    logic [DATA_WIDTH-1:0]        data;
    logic [CHARACTER_WIDTH-1:0]   ch;
    logic [PC_WIDTH-1:0]          pc_inc;
    logic [CC_ID_BITS-1:0]        cc_inc;
    logic [PC_WIDTH-1:0]          head_pc;
    logic [CC_ID_BITS-1:0]        head_cc;
    logic                         unused_instr_bits;

    assign push    = input_pc_valid && ready_q;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign head_pc = fifo_q[rd_ptr_q][ENTRY_W-1 -: PC_WIDTH];
    assign head_cc = fifo_q[rd_ptr_q][CC_ID_BITS-1:0];

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {input_pc, input_cc_id};
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d = (count_d != CNT_W'(INPUT_FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INPUT_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign opcode = instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH];
    assign data   = instr_q[DATA_WIDTH-1:0];
    assign ch     = current_characters[int'(cur_cc_q)*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign pc_inc = cur_pc_q + PC_WIDTH'(1);
    assign cc_inc = cur_cc_q + CC_ID_BITS'(1);
    assign unused_instr_bits = ^instr_q;

    always_comb begin
        state_d      = state_q;
        cur_pc_d     = cur_pc_q;
        cur_cc_d     = cur_cc_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        instr_d      = instr_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_cc_d     = out_cc_q;
        split_pc_d   = split_pc_q;
        split_pend_d = split_pend_q;
        accepts_d    = 1'b0;
        accepts_cc_d = accepts_cc_q;
        illegal_d    = illegal_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_pc_d    = head_pc;
                    cur_cc_d    = head_cc;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = MEMORY_ADDR_WIDTH'(head_pc);
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (memory_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                instr_d = memory_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                case (opcode)
                    OP_ACCEPT: begin
                        if (ch == '0) begin
                            accepts_d    = 1'b1;
                            accepts_cc_d = cur_cc_q;
                        end
                    end
                    OP_ACCEPT_PARTIAL: begin
                        accepts_d    = 1'b1;
                        accepts_cc_d = cur_cc_q;
                    end
                    OP_MATCH_CHAR: begin
                        if (ch == data[CHARACTER_WIDTH-1:0]) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_inc;
                            out_cc_d    = cc_inc;
                            state_d     = OUT1;
                        end
                    end
                    OP_NOT_MATCH_CHAR: begin
                        if (ch != data[CHARACTER_WIDTH-1:0]) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_inc;
                            out_cc_d    = cur_cc_q;
                            state_d     = OUT1;
                        end
                    end
                    OP_MATCH_ANY: begin
                        if (ch != '0) begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_inc;
                            out_cc_d    = cc_inc;
                            state_d     = OUT1;
                        end
                    end
                    OP_JMP: begin
                        out_valid_d = 1'b1;
                        out_pc_d    = data[PC_WIDTH-1:0];
                        out_cc_d    = cur_cc_q;
                        state_d     = OUT1;
                    end
                    OP_SPLIT: begin
                        out_valid_d  = 1'b1;
                        out_pc_d     = pc_inc;
                        out_cc_d     = cur_cc_q;
                        split_pc_d   = data[PC_WIDTH-1:0];
                        split_pend_d = 1'b1;
                        state_d      = OUT1;
                    end
                    OP_END_NO_ACCEPT: begin
                    end
                    default: begin
                        illegal_d = 1'b1;
                    end
                endcase
            end
            OUT1: begin
                if (output_pc_ready) begin
                    if (split_pend_q) begin
                        // cc_id is unchanged for the second SPLIT target
                        out_pc_d     = split_pc_q;
                        split_pend_d = 1'b0;
                        state_d      = OUT2;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            OUT2: begin
                if (output_pc_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_pc_q     <= '0;
            cur_cc_q     <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            instr_q      <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_cc_q     <= '0;
            split_pc_q   <= '0;
            split_pend_q <= 1'b0;
            accepts_q    <= 1'b0;
            accepts_cc_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_pc_q     <= cur_pc_d;
            cur_cc_q     <= cur_cc_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            instr_q      <= instr_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_cc_q     <= out_cc_d;
            split_pc_q   <= split_pc_d;
            split_pend_q <= split_pend_d;
            accepts_q    <= accepts_d;
            accepts_cc_q <= accepts_cc_d;
            illegal_q    <= illegal_d;
        end
    end

`ifdef REGEX_CPU_PERF_COUNTERS_EN
    logic [31:0] instr_cnt_q, instr_cnt_d, accept_cnt_q, accept_cnt_d;

    always_comb begin
        instr_cnt_d  = instr_cnt_q;
        accept_cnt_d = accept_cnt_q;
        if (state_q == EXEC && instr_cnt_q != '1) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
        if (accepts_d && accept_cnt_q != '1) begin
            accept_cnt_d = accept_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt_q  <= '0;
            accept_cnt_q <= '0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign perf_instr_count  = instr_cnt_q;
    assign perf_accept_count = accept_cnt_q;
`endif

    assign input_pc_ready  = ready_q;
    assign memory_valid    = mem_valid_q;
    assign memory_addr     = mem_addr_q;
    assign output_pc_valid = out_valid_q;
    assign output_pc       = out_pc_q;
    assign output_cc_id    = out_cc_q;
    assign accepts         = accepts_q;
    assign accepts_cc_id   = accepts_cc_q;
    assign illegal_opcode  = illegal_q;

endmodule

// File: tb/tb_regex_cpu_queued.sv
// Directed bench for regex_cpu_queued with a behavioural instruction memory.
module tb_regex_cpu_queued;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] chars;
    logic        in_valid;
    logic [7:0]  in_pc;
    logic [0:0]  in_cc;
    logic        in_ready;
    logic        mem_valid;
    logic [10:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic        out_valid;
    logic [7:0]  out_pc;
    logic [0:0]  out_cc;
    logic        out_ready;
    logic        accepts;
    logic [0:0]  acc_cc;
    logic        illegal;
`ifdef REGEX_CPU_PERF_COUNTERS_EN
    logic [31:0] perf_instr;
    logic [31:0] perf_acc;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:2047];
    logic [10:0] fetch_log [$];

    always #5 clk = ~clk;

    regex_cpu_queued dut (
        .clk                (clk),
        .rst                (rst),
        .current_characters (chars),
        .input_pc_valid     (in_valid),
        .input_pc           (in_pc),
        .input_cc_id        (in_cc),
        .input_pc_ready     (in_ready),
        .memory_valid       (mem_valid),
        .memory_addr        (mem_addr),
        .memory_ready       (mem_ready),
        .memory_data        (mem_data),
        .output_pc_valid    (out_valid),
        .output_pc          (out_pc),
        .output_cc_id       (out_cc),
        .output_pc_ready    (out_ready),
        .accepts            (accepts),
        .accepts_cc_id      (acc_cc),
`ifdef REGEX_CPU_PERF_COUNTERS_EN
        .perf_instr_count   (perf_instr),
        .perf_accept_count  (perf_acc),
`endif
        .illegal_opcode     (illegal)
    );

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            mem_data <= mem[mem_addr];
            fetch_log.push_back(mem_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] pc, input logic cc);
        int b = 0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_cc    = cc;
        while (!in_ready && b < 50) begin
            step();
            b++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_acc(input string tag, output int lat);
        lat = 0;
        while (!accepts && lat < 40) begin
            step();
            lat++;
        end
        chk(tag, {31'd0, accepts}, 32'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            step();
            if (out_valid || accepts) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int lat;
        int b;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;
        rst       = 1'b1;
        chars     = 16'h4141;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_cc     = '0;
        mem_ready = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outs", {28'd0, mem_valid, out_valid, accepts, illegal}, 32'd0);
        rst = 1'b0;
        repeat (30) step();
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_outs", {28'd0, mem_valid, out_valid, accepts, illegal}, 32'd0);

        // END_WITHOUT_ACCEPTING: nothing emitted
        push(8'h05, 1'b0);
        quiet("end_quiet", 10);
        chk("end_ready", {31'd0, in_ready}, 32'd1);
        chk("end_fetch_addr", {21'd0, fetch_log[fetch_log.size()-1]}, 32'h005);

        // MATCH_CHAR hit with cc_id wrap, checks latency
        mem[11'h010] = 16'h2041;
        push(8'h10, 1'b1);
        wait_out("mc_valid", lat);
        chk("mc_latency", lat, 4);
        chk("mc_pc", {24'd0, out_pc}, 32'h11);
        chk("mc_cc", {31'd0, out_cc}, 32'd0);
        step();
        chk("mc_done", {31'd0, out_valid}, 32'd0);

        mem[11'h010] = 16'h2042;
        push(8'h10, 1'b1);
        quiet("mc_miss", 10);

        // MATCH_ANY at pc 0xFF: pc wraps to 0, cc_id wraps to 0
        mem[11'h0FF] = 16'h5000;
        push(8'hFF, 1'b1);
        wait_out("ma_valid", lat);
        chk("ma_pc_cc", {23'd0, out_pc, out_cc}, {23'd0, 8'h00, 1'b0});
        step();

        // NOT_MATCH_CHAR: char0=0x42 != 0x41 -> pc+1, same cc
        chars = 16'h4142;
        mem[11'h080] = 16'h7041;
        push(8'h80, 1'b0);
        wait_out("nm_valid", lat);
        chk("nm_pc_cc", {23'd0, out_pc, out_cc}, {23'd0, 8'h81, 1'b0});
        step();

        // JMP keeps cc_id
        mem[11'h070] = 16'h30AB;
        push(8'h70, 1'b1);
        wait_out("jmp_valid", lat);
        chk("jmp_pc_cc", {23'd0, out_pc, out_cc}, {23'd0, 8'hAB, 1'b1});
        step();
        chk("jmp_done", {31'd0, out_valid}, 32'd0);

        // SPLIT with back-pressure on the first pc
        mem[11'h020] = 16'h1040;
        out_ready = 1'b0;
        push(8'h20, 1'b1);
        wait_out("split_valid1", lat);
        chk("split_pc1", {23'd0, out_pc, out_cc}, {23'd0, 8'h21, 1'b1});
        repeat (3) begin
            step();
            chk("split_hold", {22'd0, out_valid, out_pc, out_cc}, {22'd0, 1'b1, 8'h21, 1'b1});
        end
        out_ready = 1'b1;
        step();
        chk("split_pc2", {22'd0, out_valid, out_pc, out_cc}, {22'd0, 1'b1, 8'h40, 1'b1});
        step();
        chk("split_done", {31'd0, out_valid}, 32'd0);

        // Queue fill while fetch stalls; fetch order must match push order
        mem_ready = 1'b0;
        fetch_log.delete();
        push(8'h30, 1'b0);
        push(8'h31, 1'b0);
        push(8'h32, 1'b1);
        push(8'h33, 1'b0);
        push(8'h34, 1'b1);
        chk("fifo_full_ready", {31'd0, in_ready}, 32'd0);
        repeat (3) step();
        chk("fetch_hold", {20'd0, mem_valid, mem_addr}, {20'd0, 1'b1, 11'h030});
        mem_ready = 1'b1;
        b = 0;
        while (fetch_log.size() < 5 && b < 200) begin
            step();
            b++;
        end
        chk("fetch_count", fetch_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < fetch_log.size()) chk("fetch_order", {21'd0, fetch_log[i]}, 32'h30 + i);
        end
        repeat (10) step();
        chk("fifo_drained_ready", {31'd0, in_ready}, 32'd1);

        // ACCEPT on end-of-string in window 1
        chars = 16'h0041;
        mem[11'h050] = 16'h0000;
        push(8'h50, 1'b1);
        wait_acc("acc_pulse", lat);
        chk("acc_latency", lat, 4);
        chk("acc_cc", {31'd0, acc_cc}, 32'd1);
        chk("acc_no_pc", {31'd0, out_valid}, 32'd0);
        step();
        chk("acc_one_cycle", {31'd0, accepts}, 32'd0);

        push(8'h50, 1'b0);
        quiet("acc_drop", 10);

        mem[11'h090] = 16'h6000;
        push(8'h90, 1'b0);
        wait_acc("accp_pulse", lat);
        chk("accp_cc", {31'd0, acc_cc}, 32'd0);
        step();

        // Unknown opcode: sticky flag, no output
        chk("illegal_before", {31'd0, illegal}, 32'd0);
        mem[11'h060] = 16'hF000;
        push(8'h60, 1'b0);
        quiet("illegal_quiet", 10);
        chk("illegal_set", {31'd0, illegal}, 32'd1);
        repeat (5) step();
        chk("illegal_sticky", {31'd0, illegal}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
